// File: rtl/somador_subtrator.sv
// somador_subtrator: two's-complement adder/subtractor for the MIPS datapath.
// It is built as a ripple-carry chain of full-adder cells. Operand b is
// inverted when sub = 1, and sub is fed in as the carry-in.
// s and Cout are combinational. An optional registered stage captures the
// result and its flags when en = 1.
// The signed-overflow flag is built only when the SOMSUB_OVF_EN macro is
// defined. Without that macro, ovf and ovf_q are tied to 0.
module somador_subtrator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             Cout,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             zero_q,
    output logic             ovf_q
);

    localparam int MSB = WIDTH - 1;

    // Operand b after the conditional inversion that turns an add into a subtract.
    logic [WIDTH-1:0] b_x;
    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign b_x      = b ^ {WIDTH{sub}};
    assign carry[0] = sub;

    // Ripple-carry chain: one full-adder cell per bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]      = a[gi] ^ b_x[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
        end
    endgenerate

    assign s    = sum;
    assign Cout = carry[WIDTH];

`ifdef SOMSUB_OVF_EN
    // Signed overflow: the operands (after accounting for the operation) have
    // the same sign, and the result's sign differs from a.
    always_comb begin
        if (sub)
            ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
        else
            ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    end
`else
    assign ovf = 1'b0;
`endif

    // Next-state values for the registered stage.
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             zero_d;
    logic             ovf_d;

    // Capture the new result when en = 1; otherwise hold the current value.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (en) begin
            s_d    = sum;
            cout_d = carry[WIDTH];
            zero_d = (sum == '0);
            ovf_d  = ovf;
        end
    end

    // Registered result stage. Reset clears it asynchronously and overrides en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_somador_subtrator.sv
// Self-checking bench for somador_subtrator at WIDTH = 16.
// The bench expects ovf to be active when SOMSUB_OVF_EN is defined and 0 otherwise.
module tb_somador_subtrator;

`ifdef SOMSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        Cout;
    logic        ovf;
    logic [15:0] s_q;
    logic        cout_q;
    logic        zero_q;
    logic        ovf_q;

    int n_checks = 0;
    int n_fail   = 0;

    somador_subtrator #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .sub    (sub),
        .s      (s),
        .Cout   (Cout),
        .ovf    (ovf),
        .s_q    (s_q),
        .cout_q (cout_q),
        .zero_q (zero_q),
        .ovf_q  (ovf_q)
    );

    always #5 clk = ~clk;

    // Directed combinational vectors: a, b, sub, expected s, expected Cout,
    // and expected signed overflow.
    localparam int NV = 9;
    localparam logic [15:0] VA [NV] = '{16'h0000, 16'hffff, 16'h1234, 16'h7fff, 16'h8000,
                                        16'h0001, 16'h8000, 16'h5555, 16'h8000};
    localparam logic [15:0] VB [NV] = '{16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'h0001,
                                        16'h0001, 16'h8000, 16'h0000, 16'h7fff};
    localparam logic        VSUB [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [15:0] VS [NV] = '{16'hffff, 16'h0000, 16'h0000, 16'h8000, 16'h7fff,
                                        16'h0002, 16'h0000, 16'h5555, 16'h0001};
    localparam logic        VC [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic        VO [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0;
        #2;
        n_checks++;
        if (s_q !== 16'h0 || cout_q !== 1'b0 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0000 0 0 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("reset: s_q=%h cout_q=%b zero_q=%b ovf_q=%b", s_q, cout_q, zero_q, ovf_q);
    endtask

    task automatic test_add_sub();
        a = 16'hf101; b = 16'hf010; sub = 1'b0;
        #10;
        n_checks++;
        if (s !== 16'he111 || Cout !== 1'b1) begin
            n_fail++;
            $display("FAIL add_basic: s=%h Cout=%b required e111 1", s, Cout);
        end
        $display("add f101+f010: s=%h Cout=%b", s, Cout);
        sub = 1'b1;
        #10;
        n_checks++;
        if (s !== 16'h00f1 || Cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_basic: s=%h Cout=%b required 00f1 1", s, Cout);
        end
        $display("sub f101-f010: s=%h Cout=%b", s, Cout);
    endtask

    task automatic test_vectors();
        logic exp_o;
        for (int i = 0; i < NV; i++) begin
            a = VA[i]; b = VB[i]; sub = VSUB[i];
            #10;
            exp_o = VO[i] & OVF_ON;
            n_checks++;
            if (s !== VS[i] || Cout !== VC[i] || ovf !== exp_o) begin
                n_fail++;
                $display("FAIL vector_%0d: s=%h Cout=%b ovf=%b required %h %b %b",
                         i, s, Cout, ovf, VS[i], VC[i], exp_o);
            end
            $display("vec %0d: %h %s %h -> s=%h Cout=%b ovf=%b", i, VA[i],
                     VSUB[i] ? "-" : "+", VB[i], s, Cout, ovf);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a = 16'h1234; b = 16'h1234; sub = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_q !== 16'h0000 || cout_q !== 1'b1 || zero_q !== 1'b1 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_capture: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0000 1 1 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("reg 1234-1234: s_q=%h cout_q=%b zero_q=%b", s_q, cout_q, zero_q);
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        en = 1'b0; a = 16'h0002; b = 16'h0003; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_q !== 16'h0000 || cout_q !== 1'b1 || zero_q !== 1'b1 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_hold: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0000 1 1 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("hold en=0: s_q=%h cout_q=%b zero_q=%b", s_q, cout_q, zero_q);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_q !== 16'h0005 || cout_q !== 1'b0 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_capture: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0005 0 0 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("capture 0002+0003: s_q=%h zero_q=%b", s_q, zero_q);
    endtask

    task automatic test_back_to_back();
        // ffff+0001 then 7fff+0001, one capture per cycle.
        @(negedge clk);
        a = 16'hffff; b = 16'h0001; sub = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (s_q !== 16'h0000 || cout_q !== 1'b1 || zero_q !== 1'b1 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wrap: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0000 1 1 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("b2b ffff+0001: s_q=%h cout_q=%b zero_q=%b", s_q, cout_q, zero_q);
        @(negedge clk);
        a = 16'h7fff; b = 16'h0001;
        @(posedge clk); #1;
        n_checks++;
        if (s_q !== 16'h8000 || cout_q !== 1'b0 || zero_q !== 1'b0 || ovf_q !== OVF_ON) begin
            n_fail++;
            $display("FAIL b2b_ovf: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 8000 0 0 %b",
                     s_q, cout_q, zero_q, ovf_q, OVF_ON);
        end
        $display("b2b 7fff+0001: s_q=%h ovf_q=%b", s_q, ovf_q);
    endtask

    task automatic test_async_reset();
        // Operands keep toggling. Reset rises between edges, and the outputs
        // must clear before the next edge.
        @(negedge clk);
        a = 16'h0101; b = 16'h0202; sub = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (s_q !== 16'h0 || cout_q !== 1'b0 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0000 0 0 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("async rst: s_q=%h cout_q=%b zero_q=%b ovf_q=%b", s_q, cout_q, zero_q, ovf_q);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a = 16'h0010 + 16'(k); b = 16'h0020; sub = k[0];
            @(posedge clk); #1;
            n_checks++;
            if (s_q !== 16'h0 || cout_q !== 1'b0 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_hold_%0d: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0000 0 0 0",
                         k, s_q, cout_q, zero_q, ovf_q);
            end
            $display("rst held edge %0d: s_q=%h", k, s_q);
        end
        @(negedge clk);
        rst = 1'b0; a = 16'h0003; b = 16'h0004; sub = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (s_q !== 16'h0007 || cout_q !== 1'b0 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL first_after_rst: s_q=%h cout_q=%b zero_q=%b ovf_q=%b required 0007 0 0 0",
                     s_q, cout_q, zero_q, ovf_q);
        end
        $display("first capture after rst 0003+0004: s_q=%h", s_q);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_vectors();
        test_registered();
        test_enable_hold();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
